// File: rtl/neuron_pkg.sv
// Shared sizing and state encoding for the sonar neuron front end.
package neuron_pkg;

  localparam int unsigned BROJ_ZNACAJKI = 60;
  localparam int unsigned SIRINA        = 16;
  localparam int unsigned SIRINA_UZORKA = BROJ_ZNACAJKI * SIRINA;
  localparam int unsigned INDEKS_W      = 6;
  localparam int unsigned BROJAC_W      = 4;

  typedef enum logic [1:0] {
    PRIKUPLJANJE = 2'd0,
    CEKANJE      = 2'd1,
    PREDAJA      = 2'd2
  } stanje_t;

endpackage

// File: rtl/uzorak_sakupljac.sv
// Collects 60 serial feature words into the neuron's sample vector, waits for the
// combinational neuron to settle, then hands its registered result downstream.
module uzorak_sakupljac
  import neuron_pkg::*;
#(
  parameter int unsigned CEKANJE_CIKLUSA = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SIRINA-1:0]        ulaz_podatak,
  input  logic                     ulaz_valid,
  input  logic                     ulaz_zadnji,
  output logic                     ulaz_ready,
  output logic [SIRINA_UZORKA-1:0] uzorak,
  input  logic [SIRINA-1:0]        izlaz_neurona,
  output logic [SIRINA-1:0]        rezultat,
  output logic                     rezultat_valid,
  input  logic                     rezultat_ready,
  output logic                     greska
);

  // uzorak -> neuron -> izlaz_neurona is a CEKANJE_CIKLUSA-cycle multicycle path;
  // timing constraints must declare it as such.

  stanje_t                   stanje, stanje_d;
  logic [INDEKS_W-1:0]       indeks, indeks_d;
  logic [BROJAC_W-1:0]       brojac, brojac_d;
  logic [SIRINA-1:0]         rezultat_d;
  logic                      rezultat_valid_d;
  logic                      ulaz_ready_d;
  logic                      greska_d;
  logic [BROJ_ZNACAJKI-1:0]  upis_en;
  logic                      prijenos;
  logic                      zadnji_slot;

  assign prijenos    = ulaz_valid & ulaz_ready;
  assign zadnji_slot = (indeks == INDEKS_W'(BROJ_ZNACAJKI - 1));

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje         <= PRIKUPLJANJE;
      indeks         <= '0;
      brojac         <= '0;
      rezultat       <= '0;
      rezultat_valid <= 1'b0;
      ulaz_ready     <= 1'b0;
      greska         <= 1'b0;
    end else begin
      stanje         <= stanje_d;
      indeks         <= indeks_d;
      brojac         <= brojac_d;
      rezultat       <= rezultat_d;
      rezultat_valid <= rezultat_valid_d;
      ulaz_ready     <= ulaz_ready_d;
      greska         <= greska_d;
    end
  end

  // Sample slots: one decoded write enable per 16-bit slot, no shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uzorak <= '0;
    end else begin
      for (int unsigned k = 0; k < BROJ_ZNACAJKI; k++) begin
        if (upis_en[k]) begin
          uzorak[k*SIRINA +: SIRINA] <= ulaz_podatak;
        end
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stanje_d         = stanje;
    indeks_d         = indeks;
    brojac_d         = brojac;
    rezultat_d       = rezultat;
    rezultat_valid_d = rezultat_valid;
    ulaz_ready_d     = ulaz_ready;
    greska_d         = 1'b0;
    upis_en          = '0;

    case (stanje)
      PRIKUPLJANJE: begin
        ulaz_ready_d = 1'b1;
        if (prijenos) begin
          if (ulaz_zadnji == zadnji_slot) begin
            for (int unsigned k = 0; k < BROJ_ZNACAJKI; k++) begin
              if (indeks == INDEKS_W'(k)) begin
                upis_en[k] = 1'b1;
              end
            end
            if (zadnji_slot) begin
              ulaz_ready_d = 1'b0;
              brojac_d     = BROJAC_W'(CEKANJE_CIKLUSA);
              stanje_d     = CEKANJE;
            end else begin
              indeks_d = indeks + INDEKS_W'(1);
            end
          end else begin
            // Marker mismatch: drop the word and restart the frame
            indeks_d = '0;
            greska_d = 1'b1;
          end
        end
      end

      CEKANJE: begin
        brojac_d = brojac - BROJAC_W'(1);
        if (brojac == BROJAC_W'(1)) begin
          rezultat_d       = izlaz_neurona;
          rezultat_valid_d = 1'b1;
          stanje_d         = PREDAJA;
        end
      end

      PREDAJA: begin
        if (rezultat_ready) begin
          rezultat_valid_d = 1'b0;
          indeks_d         = '0;
          ulaz_ready_d     = 1'b1;
          stanje_d         = PRIKUPLJANJE;
        end
      end

      default: begin
        stanje_d = PRIKUPLJANJE;
      end
    endcase
  end

endmodule

// File: tb/tb_uzorak_sakupljac.sv
// Scoreboard bench: three collectors (settle 4, 1, 15) share one input stream.
module tb_uzorak_sakupljac;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  ulaz_podatak = '0;
  logic         ulaz_valid = 1'b0;
  logic         ulaz_zadnji = 1'b0;
  logic         rezultat_ready = 1'b1;

  logic         ulaz_ready_a [3];
  logic [959:0] uzorak_a [3];
  logic [15:0]  izlaz_a [3];
  logic [15:0]  rezultat_a [3];
  logic         rv_a [3];
  logic         greska_a [3];

  always #5 clk = ~clk;

  // Neuron stub: 16-bit sum of all slots, keyed
  function automatic logic [15:0] neuron_stub(input logic [959:0] u);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 60; k++) s = s + u[k*16 +: 16];
    return s ^ 16'h1234;
  endfunction

  assign izlaz_a[0] = neuron_stub(uzorak_a[0]);
  assign izlaz_a[1] = neuron_stub(uzorak_a[1]);
  assign izlaz_a[2] = neuron_stub(uzorak_a[2]);

  uzorak_sakupljac #(.CEKANJE_CIKLUSA(4)) d4 (
    .clk(clk), .rst_n(rst_n), .ulaz_podatak(ulaz_podatak), .ulaz_valid(ulaz_valid),
    .ulaz_zadnji(ulaz_zadnji), .ulaz_ready(ulaz_ready_a[0]), .uzorak(uzorak_a[0]),
    .izlaz_neurona(izlaz_a[0]), .rezultat(rezultat_a[0]), .rezultat_valid(rv_a[0]),
    .rezultat_ready(rezultat_ready), .greska(greska_a[0]));

  uzorak_sakupljac #(.CEKANJE_CIKLUSA(1)) d1 (
    .clk(clk), .rst_n(rst_n), .ulaz_podatak(ulaz_podatak), .ulaz_valid(ulaz_valid),
    .ulaz_zadnji(ulaz_zadnji), .ulaz_ready(ulaz_ready_a[1]), .uzorak(uzorak_a[1]),
    .izlaz_neurona(izlaz_a[1]), .rezultat(rezultat_a[1]), .rezultat_valid(rv_a[1]),
    .rezultat_ready(rezultat_ready), .greska(greska_a[1]));

  uzorak_sakupljac #(.CEKANJE_CIKLUSA(15)) d15 (
    .clk(clk), .rst_n(rst_n), .ulaz_podatak(ulaz_podatak), .ulaz_valid(ulaz_valid),
    .ulaz_zadnji(ulaz_zadnji), .ulaz_ready(ulaz_ready_a[2]), .uzorak(uzorak_a[2]),
    .izlaz_neurona(izlaz_a[2]), .rezultat(rezultat_a[2]), .rezultat_valid(rv_a[2]),
    .rezultat_ready(rezultat_ready), .greska(greska_a[2]));

  int ukupno = 0;
  int lose = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [15:0] red0 [$];
  logic [15:0] red1 [$];
  logic [15:0] red2 [$];
  logic [15:0] okvir [60];
  int m_idx = 0;
  logic prev_rv [3] = '{default: 1'b0};

  task automatic provjeri(input string tag, input logic [31:0] dob, input logic [31:0] ocek);
    ukupno++;
    if (dob !== ocek) begin
      lose++;
      $display("FAIL %s: dobiveno=%0h ocekivano=%0h", tag, dob, ocek);
    end
  endtask

  function automatic int lat(input int i);
    case (i)
      0: return 4;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  function automatic int red_size(input int i);
    case (i)
      0: return red0.size();
      1: return red1.size();
      default: return red2.size();
    endcase
  endfunction

  task automatic red_pop(input int i, output logic [15:0] v);
    case (i)
      0: v = red0.pop_front();
      1: v = red1.pop_front();
      default: v = red2.pop_front();
    endcase
  endtask

  function automatic logic svi_spremni();
    return ulaz_ready_a[0] && ulaz_ready_a[1] && ulaz_ready_a[2];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: latency on valid rise, value check on each handshake
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst_n) begin
        if (rv_a[i] && !prev_rv[i]) begin
          if (red_size(i) == 0) provjeri($sformatf("rv_laz%0d", i), 1, 0);
          else provjeri($sformatf("latencija%0d", i), cyc - last_acc, lat(i));
        end
        if (rv_a[i] && rezultat_ready) begin
          logic [15:0] ocek;
          if (red_size(i) == 0) provjeri($sformatf("rez_visak%0d", i), 1, 0);
          else begin
            red_pop(i, ocek);
            provjeri($sformatf("rezultat%0d", i), rezultat_a[i], ocek);
          end
        end
      end
      prev_rv[i] = rv_a[i];
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 60; k++) okvir[k] = '0;
    m_idx = 0;
  endtask

  // Sends one word; entered and left on a falling edge
  task automatic posalji(input logic [15:0] d, input logic z);
    int t;
    int idx;
    logic kraj, ok;
    logic [959:0] u;
    logic [15:0] exp_rez;
    t = 0;
    while (!svi_spremni()) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        provjeri("timeout_ready", 0, 1);
        return;
      end
    end
    ulaz_podatak = d;
    ulaz_zadnji = z;
    ulaz_valid = 1'b1;
    @(negedge clk);
    ulaz_valid = 1'b0;
    ulaz_zadnji = 1'b0;
    idx = m_idx;
    kraj = (m_idx == 59);
    ok = (z == kraj);
    if (ok) begin
      okvir[idx] = d;
      if (kraj) begin
        last_acc = cyc;
        exp_rez = '0;
        for (int k = 0; k < 60; k++) exp_rez = exp_rez + okvir[k];
        exp_rez = exp_rez ^ 16'h1234;
        red0.push_back(exp_rez);
        red1.push_back(exp_rez);
        red2.push_back(exp_rez);
        m_idx = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end else begin
      m_idx = 0;
    end
    u = uzorak_a[0];
    provjeri("greska", greska_a[0], !ok);
    provjeri(ok ? "slot" : "slot_netaknut", u[idx*16 +: 16], okvir[idx]);
  endtask

  task automatic cekaj_prazno();
    int t;
    t = 0;
    while (red0.size() != 0 || red1.size() != 0 || red2.size() != 0 || !svi_spremni()) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        provjeri("timeout_izlaz", 0, 1);
        return;
      end
    end
  endtask

  task automatic puni_okvir(input logic [15:0] baza);
    for (int k = 0; k < 60; k++) posalji(baza + 16'(k), k == 59);
  endtask

  task automatic provjeri_reset(input string tag);
    provjeri({tag, "_ready"}, ulaz_ready_a[0], 0);
    provjeri({tag, "_rv"}, rv_a[0], 0);
    provjeri({tag, "_rez"}, rezultat_a[0], 0);
    provjeri({tag, "_greska"}, greska_a[0], 0);
    provjeri({tag, "_uzorak"}, uzorak_a[0] != '0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: dobiveno=timeout ocekivano=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [959:0] u0;
    logic [15:0] ocek;
    int t;
    model_reset();
    repeat (3) @(negedge clk);
    provjeri_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    provjeri("ready_nakon_reseta", ulaz_ready_a[0], 1);

    // Basic frame: values k+1
    puni_okvir(16'd1);
    u0 = uzorak_a[0];
    provjeri("prvi_slot", u0[15:0], 16'd1);
    provjeri("zadnji_slot", u0[959:944], 16'd60);
    cekaj_prazno();

    // Random gaps, then downstream stall while input keeps pushing
    rezultat_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      posalji(16'($urandom), k == 59);
    end
    t = 0;
    while (!rv_a[0] && t < 30) begin
      @(negedge clk);
      t++;
    end
    provjeri("stall_rv_dosao", rv_a[0], 1);
    ocek = (red0.size() != 0) ? red0[0] : 16'h0;
    u0 = uzorak_a[0];
    ulaz_podatak = 16'hBEEF;
    ulaz_zadnji = 1'b0;
    ulaz_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      provjeri("stall_rv", rv_a[0], 1);
      provjeri("stall_rez", rezultat_a[0], ocek);
      provjeri("stall_ready", ulaz_ready_a[0], 0);
      provjeri("stall_greska", greska_a[0], 0);
      provjeri("stall_uzorak", uzorak_a[0] == u0, 1);
    end
    ulaz_valid = 1'b0;
    rezultat_ready = 1'b1;
    @(negedge clk);
    provjeri("predaja_rv", rv_a[0], 0);
    provjeri("predaja_ready", ulaz_ready_a[0], 1);
    cekaj_prazno();

    // Early marker on word 30
    for (int k = 0; k < 30; k++) posalji(16'd100 + 16'(k), 1'b0);
    posalji(16'hDEAD, 1'b1);
    @(negedge clk);
    provjeri("greska_pad", greska_a[0], 0);
    puni_okvir(16'd200);
    cekaj_prazno();

    // Missing marker on word 59
    for (int k = 0; k < 59; k++) posalji(16'd300 + 16'(k), 1'b0);
    posalji(16'hCAFE, 1'b0);
    repeat (20) @(negedge clk);
    provjeri("bez_rezultata", red0.size(), 0);
    puni_okvir(16'd400);
    cekaj_prazno();

    // Reset while settling
    puni_okvir(16'd500);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    red0.delete();
    red2.delete();
    model_reset();
    #1;
    provjeri_reset("reset_cekanje");
    repeat (2) begin
      @(negedge clk);
      provjeri("reset_drzi_rv", rv_a[0], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    provjeri("ready_nakon_reseta2", ulaz_ready_a[0], 1);
    provjeri("rv_nakon_reseta2", rv_a[0], 0);
    puni_okvir(16'd700);
    cekaj_prazno();

    provjeri("red_prazan", red0.size() + red1.size() + red2.size(), 0);
    $display("test done: total=%0d bad=%0d", ukupno, lose);
    $finish;
  end

endmodule
